tnoc_axi_read_arbiter: RTL and testbench

TNOC_AXI_READ_ARBITER -- requirements
Module: tnoc_axi_read_arbiter

---
 rtl/tnoc_axi_pkg.sv | 18 +
 rtl/tnoc_axi_outstanding_counter.sv | 40 ++++
 rtl/tnoc_axi_read_arbiter.sv | 177 +++++++++++++++++
 tb/tb_tnoc_axi_read_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnoc_axi_pkg.sv
// Shared definitions for the TNoC AXI read arbiter.
//   ar_state_e : AR path state (StIdle: no downstream request, StBusy: request held)
//   sel_width  : width of the requester index field, never narrower than one bit
package tnoc_axi_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } ar_state_e;

   function automatic int unsigned sel_width(input int unsigned n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/tnoc_axi_outstanding_counter.sv
// Per-requester count of AR bursts still waiting for their last R beat.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_inc        : a burst was granted this cycle
//   i_dec        : a burst completed (R handshake with rlast) this cycle
//   o_full       : count has reached MAX_OUTSTANDING, no further grants
module tnoc_axi_outstanding_counter #(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_full
);

   localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

   logic [CNT_WIDTH-1:0] count_q, count_d;

   assign o_full = (count_q == CNT_WIDTH'(MAX_OUTSTANDING));

   // Increment and decrement in the same cycle cancel; both ends saturate.
   always_comb begin
      count_d = count_q;
      if (i_inc && !i_dec && !o_full) begin
         count_d = count_q + CNT_WIDTH'(1);
      end else if (i_dec && !i_inc && (count_q != '0)) begin
         count_d = count_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/tnoc_axi_read_arbiter.sv
// Round-robin arbiter merging REQUESTERS AXI read masters onto one downstream port.
//   AR upstream   : i_arvalid / o_arready / i_arid / i_ar (packed per requester)
//   AR downstream : o_m_arvalid / i_m_arready / o_m_arid ({index, arid}) / o_m_ar
//   R downstream  : i_m_rvalid / o_m_rready / i_m_rid / i_m_rdata / i_m_rresp / i_m_rlast
//   R upstream    : o_rvalid / i_rready per requester, shared o_rid / o_rdata / o_rresp / o_rlast
// Grants are registered (one cycle AR latency) and held until the downstream accepts.
// The R path is a pure combinational demux on the index carried in the upper rid bits.
module tnoc_axi_read_arbiter
   import tnoc_axi_pkg::*;
#(
   parameter int unsigned REQUESTERS      = 4,
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned AR_WIDTH        = 64,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned SEL_WIDTH      = sel_width(REQUESTERS)
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [REQUESTERS-1:0]           i_arvalid,
   output logic [REQUESTERS-1:0]           o_arready,
   input  logic [REQUESTERS*ID_WIDTH-1:0]  i_arid,
   input  logic [REQUESTERS*AR_WIDTH-1:0]  i_ar,
   output logic                            o_m_arvalid,
   input  logic                            i_m_arready,
   output logic [ID_WIDTH+SEL_WIDTH-1:0]   o_m_arid,
   output logic [AR_WIDTH-1:0]             o_m_ar,
   input  logic                            i_m_rvalid,
   output logic                            o_m_rready,
   input  logic [ID_WIDTH+SEL_WIDTH-1:0]   i_m_rid,
   input  logic [DATA_WIDTH-1:0]           i_m_rdata,
   input  logic [1:0]                      i_m_rresp,
   input  logic                            i_m_rlast,
   output logic [REQUESTERS-1:0]           o_rvalid,
   input  logic [REQUESTERS-1:0]           i_rready,
   output logic [ID_WIDTH-1:0]             o_rid,
   output logic [DATA_WIDTH-1:0]           o_rdata,
   output logic [1:0]                      o_rresp,
   output logic                            o_rlast
);

   ar_state_e state_q, state_d;

   logic [SEL_WIDTH-1:0]          ptr_q, ptr_next;
   logic [SEL_WIDTH-1:0]          grant_idx;
   logic                          grant_valid;
   logic                          ar_fire;
   logic [REQUESTERS-1:0]         eligible, full, grant_onehot, dec;
   logic [ID_WIDTH-1:0]           sel_arid;
   logic [AR_WIDTH-1:0]           sel_ar;
   logic [ID_WIDTH+SEL_WIDTH-1:0] m_arid_q;
   logic [AR_WIDTH-1:0]           m_ar_q;
   logic [SEL_WIDTH-1:0]          rid_sel;
   logic                          rid_hit;

   // Index of the requester `off` positions after `ptr`, wrapping at REQUESTERS.
   function automatic int unsigned rr_index(input int unsigned ptr, input int unsigned off);
      int unsigned sum;
      sum = ptr + off;
      return (sum >= REQUESTERS) ? sum - REQUESTERS : sum;
   endfunction

   // ---------------------------------------------------------------- AR arbitration

   assign eligible = i_arvalid & ~full;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         if (!grant_valid && eligible[rr_index(int'(ptr_q), i)]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_WIDTH'(rr_index(int'(ptr_q), i));
         end
      end
   end

   always_comb begin
      grant_onehot = '0;
      sel_arid     = '0;
      sel_ar       = '0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         if (grant_valid && (grant_idx == SEL_WIDTH'(k))) begin
            grant_onehot[k] = 1'b1;
            sel_arid        = i_arid[k*ID_WIDTH +: ID_WIDTH];
            sel_ar          = i_ar[k*AR_WIDTH +: AR_WIDTH];
         end
      end
   end

   assign ptr_next = (grant_idx == SEL_WIDTH'(REQUESTERS - 1)) ? '0
                                                               : grant_idx + SEL_WIDTH'(1);

   // ---------------------------------------------------------------- AR FSM

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant_valid) state_d = StBusy;
         StBusy:  if (i_m_arready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // No grant while reset is applied, so the counters and pointer stay cleared.
   always_comb begin
      o_m_arvalid = (state_q == StBusy);
      o_arready   = '0;
      ar_fire     = 1'b0;
      if ((state_q == StIdle) && !i_rst) begin
         o_arready = grant_onehot;
         ar_fire   = grant_valid;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q    <= '0;
         m_arid_q <= '0;
         m_ar_q   <= '0;
      end else if (ar_fire) begin
         ptr_q    <= ptr_next;
         m_arid_q <= {grant_idx, sel_arid};
         m_ar_q   <= sel_ar;
      end
   end

   assign o_m_arid = m_arid_q;
   assign o_m_ar   = m_ar_q;

   // ---------------------------------------------------------------- R demux

   assign rid_sel = i_m_rid[ID_WIDTH +: SEL_WIDTH];
   assign rid_hit = ({1'b0, rid_sel} < (SEL_WIDTH + 1)'(REQUESTERS));

   // Beats for a nonexistent requester are sunk (rready=1) so the downstream never stalls.
   always_comb begin
      o_rvalid   = '0;
      o_m_rready = 1'b1;
      dec        = '0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         if (rid_hit && (rid_sel == SEL_WIDTH'(k))) begin
            o_rvalid[k] = i_m_rvalid;
            o_m_rready  = i_rready[k];
            dec[k]      = i_m_rvalid & i_rready[k] & i_m_rlast;
         end
      end
   end

   assign o_rid   = i_m_rid[ID_WIDTH-1:0];
   assign o_rdata = i_m_rdata;
   assign o_rresp = i_m_rresp;
   assign o_rlast = i_m_rlast;

   // ---------------------------------------------------------------- outstanding counters

   for (genvar k = 0; k < REQUESTERS; k++) begin : g_cnt
      tnoc_axi_outstanding_counter #(
         .MAX_OUTSTANDING(MAX_OUTSTANDING)
      ) u_cnt (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_inc  (o_arready[k]),
         .i_dec  (dec[k]),
         .o_full (full[k])
      );
   end

endmodule

// File: tb/tb_tnoc_axi_read_arbiter.sv
// Self-checking bench for tnoc_axi_read_arbiter: a scoreboard of expected downstream AR
// beats plus direct checks of the combinational R demux. A second instance with three
// requesters covers the out-of-range rid index.
module tb_tnoc_axi_read_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [3:0]    arvalid, arready;
   logic [15:0]   arid;
   logic [255:0]  ar;
   logic          m_arvalid, m_arready;
   logic [5:0]    m_arid;
   logic [63:0]   m_ar;
   logic          m_rvalid, m_rready;
   logic [5:0]    m_rid;
   logic [63:0]   m_rdata;
   logic [1:0]    m_rresp;
   logic          m_rlast;
   logic [3:0]    rvalid, rready;
   logic [3:0]    rid;
   logic [63:0]   rdata;
   logic [1:0]    rresp;
   logic          rlast;

   logic [2:0]    arready3, rvalid3;
   logic          m_arvalid3, m_rready3, rlast3;
   logic [5:0]    m_arid3;
   logic [63:0]   m_ar3, rdata3;
   logic [3:0]    rid3;
   logic [1:0]    rresp3;

   tnoc_axi_read_arbiter dut (
      .i_clk(clk), .i_rst(rst),
      .i_arvalid(arvalid), .o_arready(arready), .i_arid(arid), .i_ar(ar),
      .o_m_arvalid(m_arvalid), .i_m_arready(m_arready), .o_m_arid(m_arid), .o_m_ar(m_ar),
      .i_m_rvalid(m_rvalid), .o_m_rready(m_rready), .i_m_rid(m_rid),
      .i_m_rdata(m_rdata), .i_m_rresp(m_rresp), .i_m_rlast(m_rlast),
      .o_rvalid(rvalid), .i_rready(rready), .o_rid(rid),
      .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast)
   );

   tnoc_axi_read_arbiter #(.REQUESTERS(3)) dut3 (
      .i_clk(clk), .i_rst(rst),
      .i_arvalid(3'b000), .o_arready(arready3), .i_arid(12'h000), .i_ar(192'd0),
      .o_m_arvalid(m_arvalid3), .i_m_arready(1'b0), .o_m_arid(m_arid3), .o_m_ar(m_ar3),
      .i_m_rvalid(m_rvalid), .o_m_rready(m_rready3), .i_m_rid(m_rid),
      .i_m_rdata(m_rdata), .i_m_rresp(m_rresp), .i_m_rlast(m_rlast),
      .o_rvalid(rvalid3), .i_rready(rready[2:0]), .o_rid(rid3),
      .o_rdata(rdata3), .o_rresp(rresp3), .o_rlast(rlast3)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Stimulus encoding: arid and payload carry the requester and its burst sequence number.
   function automatic logic [5:0] exp_id(input int k, input int s);
      return {2'(k), 4'(k + s)};
   endfunction

   function automatic logic [63:0] exp_ar(input int k, input int s);
      return {16'hA5A5, 8'(k), 8'h00, 32'(s)};
   endfunction

   typedef struct {
      int k;
      int s;
   } exp_t;

   exp_t exp_q[$];
   int   exp_seq[4];
   int   pend[4];
   int   seq[4];
   logic [3:0] ar_hs;

   task automatic push(input int k);
      exp_t e;
      e.k = k;
      e.s = exp_seq[k];
      exp_seq[k]++;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag, input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         step();
         n++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
      repeat (6) step();
   endtask

   task automatic wait_busy(input string tag);
      int n;
      n = 0;
      while (!m_arvalid && n < 10) begin
         step();
         n++;
      end
      check(tag, 64'(m_arvalid), 64'd1);
   endtask

   // Upstream masters: each holds arvalid while it has pending bursts.
   initial begin
      arvalid = '0;
      arid    = '0;
      ar      = '0;
      for (int k = 0; k < 4; k++) begin
         pend[k] = 0;
         seq[k]  = 0;
      end
      forever begin
         @(posedge clk);
         for (int k = 0; k < 4; k++) begin
            if (ar_hs[k]) begin
               pend[k]--;
               seq[k]++;
            end
         end
         #2;
         for (int k = 0; k < 4; k++) begin
            arvalid[k]        = (pend[k] > 0);
            arid[k*4 +: 4]    = 4'(k + seq[k]);
            ar[k*64 +: 64]    = {16'hA5A5, 8'(k), 8'h00, 32'(seq[k])};
         end
      end
   end

   // Downstream AR monitor: every accepted beat must match the scoreboard head.
   initial begin
      exp_t e;
      logic have;
      ar_hs = '0;
      forever begin
         @(negedge clk);
         ar_hs = arready & arvalid;
         if (m_arvalid && m_arready) begin
            have = (exp_q.size() != 0);
            check("ar_expected", 64'(have), 64'd1);
            if (have) begin
               e = exp_q.pop_front();
               check("ar_id", 64'(m_arid), 64'(exp_id(e.k, e.s)));
               check("ar_payload", m_ar, exp_ar(e.k, e.s));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 4; k++) exp_seq[k] = 0;
      rst = 1'b1; m_arready = 1'b0;
      m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; rready = '0;
      repeat (3) step();

      // Reset state, with every requester requesting.
      for (int k = 0; k < 4; k++) pend[k] = 1;
      step(); step();
      @(negedge clk);
      check("rst_arready", 64'(arready), 64'h0);
      check("rst_m_arvalid", 64'(m_arvalid), 64'h0);
      check("rst_m_arid", 64'(m_arid), 64'h0);
      check("rst_m_ar", m_ar, 64'h0);
      for (int k = 0; k < 4; k++) pend[k] = 0;
      step(); step();
      rst = 1'b0;
      step();

      // Requesters 0 and 2 together: 0 first, 2 after the downstream handshake.
      push(0); push(2);
      pend[0] = 1; pend[2] = 1;
      @(negedge clk);
      check("b_first_grant", 64'(arready), 64'b0001);
      step();
      repeat (3) step();
      check("b_busy_hold", 64'(m_arvalid), 64'd1);
      check("b_busy_arready", 64'(arready), 64'h0);
      m_arready = 1'b1;
      wait_drain("b_drain", 40);

      // Pointer now at 3.
      push(3); push(0); push(1); push(2);
      for (int k = 0; k < 4; k++) pend[k] = 1;
      wait_drain("c_drain", 40);

      // Reset while a grant to requester 1 is held downstream.
      m_arready = 1'b0;
      pend[1] = 1;
      wait_busy("e_busy");
      check("e_arid", 64'(m_arid), 64'(exp_id(1, exp_seq[1])));
      rst = 1'b1;
      step();
      check("e_rst_arvalid", 64'(m_arvalid), 64'd0);
      check("e_rst_arid", 64'(m_arid), 64'd0);
      check("e_rst_ar", m_ar, 64'd0);
      rst = 1'b0;
      exp_seq[1]++;  // abandoned burst consumed a sequence number upstream
      step();

      // All valid after reset: pointer restarts at 0, arvalid toggles each burst.
      m_arready = 1'b1;
      push(0); push(1); push(2); push(3); push(0);
      pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
      wait_busy("f_busy");
      for (int i = 0; i < 8; i++) begin
         check("f_toggle", 64'(m_arvalid), (i % 2 == 0) ? 64'd1 : 64'd0);
         step();
      end
      wait_drain("f_drain", 40);

      // Complete requester 1's only burst; also checks the R demux.
      m_rvalid = 1'b1; m_rid = {2'd1, 4'h7}; m_rlast = 1'b1; rready = 4'b0010;
      m_rdata = 64'hDEAD_BEEF_0123_4567; m_rresp = 2'b10;
      @(negedge clk);
      check("g0_rvalid", 64'(rvalid), 64'b0010);
      check("g0_m_rready", 64'(m_rready), 64'd1);
      check("g0_rid", 64'(rid), 64'h7);
      check("g0_rdata", rdata, 64'hDEAD_BEEF_0123_4567);
      check("g0_rresp_rlast", 64'({rresp, rlast}), 64'b101);
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;

      // Requester 1 wants 5 bursts: only 4 are granted, others keep going.
      push(1); push(3); push(0); push(1); push(1); push(1);
      pend[1] = 5; pend[0] = 1; pend[3] = 1;
      wait_drain("g_drain", 80);
      @(negedge clk);
      check("g_r1_blocked", 64'({arvalid[1], arready[1]}), 64'b10);
      step();
      push(2); push(0);
      pend[2] = 1; pend[0] = 1;
      wait_drain("g_others", 40);

      // Completion for requester 1 coincides with a new grant to requester 1.
      m_arready = 1'b0;
      push(2);
      pend[2] = 1;
      wait_busy("h_busy");
      m_rvalid = 1'b1; m_rid = {2'd1, 4'h3}; m_rlast = 1'b1;
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      push(1);
      m_arready = 1'b1;
      step();
      m_rvalid = 1'b1; m_rlast = 1'b1;
      @(negedge clk);
      check("h_grant", 64'(arready), 64'b0010);
      check("h_rvalid", 64'(rvalid), 64'b0010);
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      // Count stayed at 3: exactly one more burst fits.
      push(1);
      pend[1] = 2;
      wait_drain("h_drain", 40);
      @(negedge clk);
      check("h_r1_full", 64'({arvalid[1], arready[1]}), 64'b10);
      step();

      // R backpressure on requester 3, and out-of-range index on the 3-requester arbiter.
      m_rvalid = 1'b1; m_rid = {2'd3, 4'hA}; rready = 4'b0111;
      @(negedge clk);
      check("i_rvalid", 64'(rvalid), 64'b1000);
      check("i_m_rready_low", 64'(m_rready), 64'd0);
      check("i3_drop_rvalid", 64'(rvalid3), 64'd0);
      check("i3_drop_rready", 64'(m_rready3), 64'd1);
      step();
      rready = 4'b1000;
      @(negedge clk);
      check("i_m_rready_high", 64'(m_rready), 64'd1);
      check("i3_drop_rready_b", 64'(m_rready3), 64'd1);
      step();
      m_rid = {2'd2, 4'hA}; rready = 4'b0000;
      @(negedge clk);
      check("i3_rvalid", 64'(rvalid3), 64'b100);
      check("i3_m_rready", 64'(m_rready3), 64'd0);
      check("i3_rid", 64'(rid3), 64'hA);
      step();
      m_rvalid = 1'b0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
